dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Shares the single data-cache request port between two requesters: the load/store unit (port L: loads, stores, AMO sub-accesses) and the MMU page-table walker (port P: loads only).
- Sits between the LSU/MMU and the data bus.
- Provides round-robin arbitration, an LSU lock for atomic sequences, flush draining, and a response watchdog.

Parameters:
- XLEN, 32, address/data width.
- ST_OPS_W, 3, width of store-operation encoding.
- TIMEOUT_CYC, 1024, cycles an outstanding access may wait for ack before abort; must be ≥4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- lsu_ld_req_i  in  1  LSU load request, held until lsu_ack_o or lsu_flush_i.
- lsu_st_req_i  in  1  LSU store request, same rules.
- lsu_addr_i  in  XLEN  LSU physical address.
- lsu_w_data_i  in  XLEN  LSU store data.
- lsu_st_ops_i  in  ST_OPS_W  LSU store size/op.
- lsu_lock_i  in  1  keep the bus for LSU across back-to-back accesses (AMO).
- lsu_flush_i  in  1  pipeline flush of LSU.
- lsu_ack_o  out  1  LSU access complete.
- lsu_r_data_o  out  XLEN  LSU read data, valid with lsu_ack_o.
- ptw_ld_req_i  in  1  walker load request, held until ptw_ack_o.
- ptw_addr_i  in  XLEN  walker physical address.
- ptw_ack_o  out  1  walker access complete.
- ptw_r_data_o  out  XLEN  walker read data.
- dbus_ld_req_o  out  1  load request to dcache.
- dbus_st_req_o  out  1  store request to dcache.
- dbus_addr_o  out  XLEN  address.
- dbus_w_data_o  out  XLEN  store data.
- dbus_st_ops_o  out  ST_OPS_W  store op.
- dbus_ack_i  in  1  dcache completion.
- dbus_r_data_i  in  XLEN  dcache read data.
- timeout_err_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset:
  - State IDLE; all dbus_* outputs, acks and timeout_err_o are 0.
  - lock_q=0; last_grant=P, so L wins the first tie; watchdog=0.
- States: IDLE, BUSY_L, BUSY_P, DRAIN.
- All dbus_* outputs are registered. Acks and read data are combinational pass-through of dbus_ack_i/dbus_r_data_i gated by owner.
- IDLE:
  - Candidates: L if (lsu_ld_req_i|lsu_st_req_i) & ~lsu_flush_i; P if ptw_ld_req_i & ~lock_q.
  - One candidate is granted directly. With two candidates, the one ≠ last_grant wins.
  - On grant: latch addr/w_data/st_ops/ld-or-st into dbus_* regs, update last_grant, clear watchdog, move to BUSY_L/BUSY_P.
  - Request seen in cycle N gives dbus req high in cycle N+1.
  - If lsu_ld_req_i and lsu_st_req_i are both high, the store is issued and a simulation assertion fires.
- BUSY_x:
  - dbus req and payload are held stable.
  - On dbus_ack_i: assert x's ack with dbus_r_data_i in the same cycle; clear dbus req regs; go to IDLE next cycle.
  - Minimum spacing is 2 cycles per access. Requesters drop req the cycle after ack. The arbiter never samples requests in the ack cycle.
- Lock:
  - lock_q is set at an L grant when lsu_lock_i=1.
  - lock_q is cleared in IDLE when lsu_lock_i=0, and on lsu_flush_i.
  - While lock_q=1, P is never granted.
- Flush:
  - lsu_flush_i in BUSY_L moves to DRAIN. The downstream access completes, but lsu_ack_o stays 0 on its ack.
  - DRAIN goes to IDLE on ack.
  - Flush does not affect BUSY_P.
  - Flush and ack in the same BUSY_L cycle: the ack is forwarded, and the next state is IDLE.
- Watchdog:
  - Increments each cycle in BUSY_x/DRAIN and saturates.
  - On reaching TIMEOUT_CYC-1 without ack: pulse timeout_err_o, clear dbus req, go to IDLE, and give no ack to the owner.
  - Ack in the same cycle wins: normal completion, no error.
- Reset mid-transaction: the next cycle matches the reset values above. Any in-flight access is abandoned.

Decomposition:
- dbus_arb_defs.svh holds type_dbus_arb_state_e, the requester-id enum (ARB_LSU, ARB_PTW) and the default TIMEOUT_CYC.
- Sub-module dbus_arb_rr: 2-way round-robin picker with last_grant register, inputs req[1:0]/mask, output one-hot grant.

Test Plan:
- Single LSU load at 0x8000_0010:
  - dbus_ld_req_o rises 1 cycle after lsu_ld_req_i.
  - With dbus_ack_i 3 cycles later and r_data 0xDEAD_BEEF, lsu_ack_o=1 with that data in the same cycle.
  - dbus_ld_req_o is 0 the next cycle.
- L and P requesting simultaneously from reset:
  - Grant order is L, P, L, P over 4 accesses.
  - ptw_ack_o never coincides with lsu_ack_o.
- AMO with lsu_lock_i=1 and P requesting throughout:
  - Load then store are both granted to L back-to-back.
  - P is granted only after lock drops.
- lsu_flush_i in the 2nd cycle of BUSY_L:
  - The dcache ack arrives with lsu_ack_o=0.
  - A pending P request is granted in the following IDLE cycle.
- TIMEOUT_CYC=8 with no ack:
  - timeout_err_o pulses in the 8th busy cycle, dbus req drops, and no ack is given.
  - Repeat with ack in that same cycle: normal ack, no error.
- Reset asserted during BUSY_P:
  - The next cycle has all outputs 0 and state IDLE.
  - The subsequent tie grants L.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// Shared types and defaults for the data-bus arbiter between the LSU and the page-table walker.
package dbus_arbiter_pkg;

  localparam int unsigned DEFAULT_XLEN        = 32;
  localparam int unsigned DEFAULT_ST_OPS_W    = 3;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_L = 2'd1,
    ST_BUSY_P = 2'd2,
    ST_DRAIN  = 2'd3
  } type_dbus_arb_state_e;

  typedef enum logic {
    ARB_LSU = 1'b0,
    ARB_PTW = 1'b1
  } arb_id_e;

endpackage

// File: rtl/dbus_arb_rr.sv
// Two-way round-robin picker; bit 0 is the LSU, bit 1 the walker.
module dbus_arb_rr
  import dbus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       take,
  output logic [1:0] grant_c
);

  arb_id_e    last_q;
  logic [1:0] eligible;

  assign eligible = req & ~mask;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_c = eligible;
    if (eligible == 2'b11) begin
      grant_c = (last_q == ARB_PTW) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= ARB_PTW;
    end else if (take && (grant_c != 2'b00)) begin
      last_q <= grant_c[1] ? ARB_PTW : ARB_LSU;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares the data-cache request port between the LSU and the MMU walker, with AMO lock,
// flush draining and a response watchdog.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned XLEN        = DEFAULT_XLEN,
  parameter int unsigned ST_OPS_W    = DEFAULT_ST_OPS_W,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lsu_ld_req_i,
  input  logic                lsu_st_req_i,
  input  logic [XLEN-1:0]     lsu_addr_i,
  input  logic [XLEN-1:0]     lsu_w_data_i,
  input  logic [ST_OPS_W-1:0] lsu_st_ops_i,
  input  logic                lsu_lock_i,
  input  logic                lsu_flush_i,
  output logic                lsu_ack_o,
  output logic [XLEN-1:0]     lsu_r_data_o,
  input  logic                ptw_ld_req_i,
  input  logic [XLEN-1:0]     ptw_addr_i,
  output logic                ptw_ack_o,
  output logic [XLEN-1:0]     ptw_r_data_o,
  output logic                dbus_ld_req_o,
  output logic                dbus_st_req_o,
  output logic [XLEN-1:0]     dbus_addr_o,
  output logic [XLEN-1:0]     dbus_w_data_o,
  output logic [ST_OPS_W-1:0] dbus_st_ops_o,
  input  logic                dbus_ack_i,
  input  logic [XLEN-1:0]     dbus_r_data_i,
  output logic                timeout_err_o
);

  localparam int unsigned       WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  type_dbus_arb_state_e state_q, state_d;
  logic                 ld_q, ld_d, st_q, st_d;
  logic [XLEN-1:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [ST_OPS_W-1:0]  ops_q, ops_d;
  logic                 lock_q, lock_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 l_cand, timeout_hit, done;
  logic [1:0]           grant_c;

  assign l_cand      = (lsu_ld_req_i || lsu_st_req_i) && !lsu_flush_i;
  assign timeout_hit = (state_q != ST_IDLE) && (wd_q == WD_LAST) && !dbus_ack_i;
  assign done        = dbus_ack_i || timeout_hit;

  dbus_arb_rr u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({ptw_ld_req_i, l_cand}),
    .mask    ({lock_q, 1'b0}),
    .take    (state_q == ST_IDLE),
    .grant_c (grant_c)
  );

  // Next-state and next-output logic for the registered bus side.
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    st_d    = st_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ops_d   = ops_q;
    lock_d  = lock_q;
    wd_d    = (wd_q == WD_LAST) ? wd_q : wd_q + WD_W'(1);
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (grant_c[0]) begin
          st_d    = lsu_st_req_i;
          ld_d    = lsu_ld_req_i && !lsu_st_req_i;
          addr_d  = lsu_addr_i;
          wdata_d = lsu_w_data_i;
          ops_d   = lsu_st_ops_i;
          lock_d  = lsu_lock_i;
          state_d = ST_BUSY_L;
        end else begin
          if (!lsu_lock_i) lock_d = 1'b0;
          if (grant_c[1]) begin
            ld_d    = 1'b1;
            st_d    = 1'b0;
            addr_d  = ptw_addr_i;
            wdata_d = '0;
            ops_d   = '0;
            state_d = ST_BUSY_P;
          end
        end
      end
      ST_BUSY_L: begin
        if (done) begin
          ld_d    = 1'b0;
          st_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (lsu_flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_BUSY_P, ST_DRAIN: begin
        if (done) begin
          ld_d    = 1'b0;
          st_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (lsu_flush_i) lock_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ops_q   <= '0;
      lock_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ops_q   <= ops_d;
      lock_q  <= lock_d;
      wd_q    <= wd_d;
    end
  end

  assign dbus_ld_req_o = ld_q;
  assign dbus_st_req_o = st_q;
  assign dbus_addr_o   = addr_q;
  assign dbus_w_data_o = wdata_q;
  assign dbus_st_ops_o = ops_q;

  // Completion is forwarded in the ack cycle itself; a drained access answers nobody.
  assign lsu_ack_o     = (state_q == ST_BUSY_L) && dbus_ack_i;
  assign ptw_ack_o     = (state_q == ST_BUSY_P) && dbus_ack_i;
  assign lsu_r_data_o  = lsu_ack_o ? dbus_r_data_i : '0;
  assign ptw_r_data_o  = ptw_ack_o ? dbus_r_data_i : '0;
  assign timeout_err_o = timeout_hit;

  a_ld_st_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(lsu_ld_req_i && lsu_st_req_i));

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scenario bench for dbus_arbiter: expected grants are queued as stimulus is applied, checked at grant and ack.
module tb_dbus_arbiter;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ST_OPS_W    = 3;
  localparam int unsigned TIMEOUT_CYC = 8;

  typedef struct packed {
    logic            ptw;
    logic            st;
    logic [XLEN-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic                clk;
  logic                rst_n;
  logic                lsu_ld_req_i, lsu_st_req_i, lsu_lock_i, lsu_flush_i;
  logic [XLEN-1:0]     lsu_addr_i, lsu_w_data_i;
  logic [ST_OPS_W-1:0] lsu_st_ops_i;
  logic                lsu_ack_o;
  logic [XLEN-1:0]     lsu_r_data_o;
  logic                ptw_ld_req_i;
  logic [XLEN-1:0]     ptw_addr_i;
  logic                ptw_ack_o;
  logic [XLEN-1:0]     ptw_r_data_o;
  logic                dbus_ld_req_o, dbus_st_req_o;
  logic [XLEN-1:0]     dbus_addr_o, dbus_w_data_o;
  logic [ST_OPS_W-1:0] dbus_st_ops_o;
  logic                dbus_ack_i;
  logic [XLEN-1:0]     dbus_r_data_i;
  logic                timeout_err_o;

  dbus_arbiter #(
    .XLEN        (XLEN),
    .ST_OPS_W    (ST_OPS_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lsu_ld_req_i  (lsu_ld_req_i),
    .lsu_st_req_i  (lsu_st_req_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_w_data_i  (lsu_w_data_i),
    .lsu_st_ops_i  (lsu_st_ops_i),
    .lsu_lock_i    (lsu_lock_i),
    .lsu_flush_i   (lsu_flush_i),
    .lsu_ack_o     (lsu_ack_o),
    .lsu_r_data_o  (lsu_r_data_o),
    .ptw_ld_req_i  (ptw_ld_req_i),
    .ptw_addr_i    (ptw_addr_i),
    .ptw_ack_o     (ptw_ack_o),
    .ptw_r_data_o  (ptw_r_data_o),
    .dbus_ld_req_o (dbus_ld_req_o),
    .dbus_st_req_o (dbus_st_req_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_w_data_o (dbus_w_data_o),
    .dbus_st_ops_o (dbus_st_ops_o),
    .dbus_ack_i    (dbus_ack_i),
    .dbus_r_data_i (dbus_r_data_i),
    .timeout_err_o (timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lsu_ld_req_i  = 1'b0;
    lsu_st_req_i  = 1'b0;
    lsu_lock_i    = 1'b0;
    lsu_flush_i   = 1'b0;
    lsu_addr_i    = '0;
    lsu_w_data_i  = '0;
    lsu_st_ops_i  = '0;
    ptw_ld_req_i  = 1'b0;
    ptw_addr_i    = '0;
    dbus_ack_i    = 1'b0;
    dbus_r_data_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Advance until a bus request is visible, bounded by max_cyc cycles.
  task automatic wait_bus(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (dbus_ld_req_o || dbus_st_req_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    dbus_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({dbus_ld_req_o, dbus_st_req_o, lsu_ack_o, ptw_ack_o, timeout_err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {dbus_ld_req_o, dbus_st_req_o, lsu_ack_o, ptw_ack_o, timeout_err_o});
    end
    n_checks++;
    if ({dbus_addr_o, dbus_w_data_o, dbus_st_ops_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: got addr=%h wdata=%h ops=%h expected all 0",
               dbus_addr_o, dbus_w_data_o, dbus_st_ops_o);
    end
    dbus_ack_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_load();
    exp_t e;
    do_reset();
    lsu_ld_req_i = 1'b1;
    lsu_addr_i   = 32'h8000_0010;
    exp_q.push_back('{ptw: 1'b0, st: 1'b0, addr: 32'h8000_0010});
    #1;
    n_checks++;
    if (dbus_ld_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: dbus_ld_req_o got %b expected 0", dbus_ld_req_o);
    end
    tick();
    n_checks++;
    if ({dbus_ld_req_o, dbus_st_req_o, dbus_addr_o} !== {2'b10, exp_q[0].addr}) begin
      n_fail++;
      $display("FAIL single_issue: got ld=%b st=%b addr=%h expected ld=1 st=0 addr=%h",
               dbus_ld_req_o, dbus_st_req_o, dbus_addr_o, exp_q[0].addr);
    end
    tick();
    tick();
    n_checks++;
    if ({dbus_ld_req_o, dbus_addr_o} !== {1'b1, exp_q[0].addr}) begin
      n_fail++;
      $display("FAIL single_hold: got ld=%b addr=%h expected ld=1 addr=%h",
               dbus_ld_req_o, dbus_addr_o, exp_q[0].addr);
    end
    tick();
    dbus_ack_i    = 1'b1;
    dbus_r_data_i = 32'hDEAD_BEEF;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if ({ptw_ack_o, lsu_ack_o} !== (e.ptw ? 2'b10 : 2'b01) || lsu_r_data_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_ack: got ptw_ack=%b lsu_ack=%b data=%h expected lsu_ack=1 data=deadbeef",
               ptw_ack_o, lsu_ack_o, lsu_r_data_o);
    end
    tick();
    dbus_ack_i   = 1'b0;
    lsu_ld_req_i = 1'b0;
    #1;
    n_checks++;
    if ({dbus_ld_req_o, lsu_ack_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_release: got ld=%b lsu_ack=%b expected 0 0", dbus_ld_req_o, lsu_ack_o);
    end
  endtask

  task automatic test_round_robin();
    exp_t            e;
    bit              seen;
    logic [XLEN-1:0] rd;
    do_reset();
    exp_q.push_back('{ptw: 1'b0, st: 1'b0, addr: 32'h0000_1000});
    exp_q.push_back('{ptw: 1'b1, st: 1'b0, addr: 32'h0000_2000});
    exp_q.push_back('{ptw: 1'b0, st: 1'b0, addr: 32'h0000_1004});
    exp_q.push_back('{ptw: 1'b1, st: 1'b0, addr: 32'h0000_2004});
    lsu_ld_req_i = 1'b1;
    lsu_addr_i   = 32'h0000_1000;
    ptw_ld_req_i = 1'b1;
    ptw_addr_i   = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      wait_bus(6, seen);
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL rr_no_grant: access %0d got no bus request within 6 cycles", k);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (dbus_addr_o !== e.addr) begin
        n_fail++;
        $display("FAIL rr_order: access %0d addr got %h expected %h", k, dbus_addr_o, e.addr);
      end
      tick();
      rd            = 32'hA5A5_0000 + 32'(k);
      dbus_ack_i    = 1'b1;
      dbus_r_data_i = rd;
      #1;
      n_checks++;
      if ({ptw_ack_o, lsu_ack_o} !== (e.ptw ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rr_ack_owner: access %0d got ptw_ack=%b lsu_ack=%b expected ptw=%b",
                 k, ptw_ack_o, lsu_ack_o, e.ptw);
      end
      n_checks++;
      if ((e.ptw ? ptw_r_data_o : lsu_r_data_o) !== rd) begin
        n_fail++;
        $display("FAIL rr_data: access %0d got lsu=%h ptw=%h expected %h",
                 k, lsu_r_data_o, ptw_r_data_o, rd);
      end
      tick();
      dbus_ack_i = 1'b0;
      if (e.ptw) ptw_addr_i = ptw_addr_i + 32'd4;
      else       lsu_addr_i = lsu_addr_i + 32'd4;
    end
    lsu_ld_req_i = 1'b0;
    ptw_ld_req_i = 1'b0;
  endtask

  task automatic test_amo_lock();
    exp_t            e;
    bit              seen;
    logic [XLEN-1:0] rd;
    do_reset();
    exp_q.push_back('{ptw: 1'b0, st: 1'b0, addr: 32'h0000_3000});
    exp_q.push_back('{ptw: 1'b0, st: 1'b1, addr: 32'h0000_3000});
    exp_q.push_back('{ptw: 1'b1, st: 1'b0, addr: 32'h0000_4000});
    ptw_ld_req_i = 1'b1;
    ptw_addr_i   = 32'h0000_4000;
    lsu_ld_req_i = 1'b1;
    lsu_lock_i   = 1'b1;
    lsu_addr_i   = 32'h0000_3000;
    for (int k = 0; k < 3; k++) begin
      wait_bus(6, seen);
      e = exp_q.pop_front();
      n_checks++;
      if (!seen || {dbus_st_req_o, dbus_ld_req_o, dbus_addr_o} !== {e.st, !e.st, e.addr}) begin
        n_fail++;
        $display("FAIL amo_grant: step %0d got st=%b ld=%b addr=%h expected st=%b addr=%h",
                 k, dbus_st_req_o, dbus_ld_req_o, dbus_addr_o, e.st, e.addr);
      end
      if (e.st) begin
        n_checks++;
        if ({dbus_w_data_o, dbus_st_ops_o} !== {32'h1234_5678, 3'd2}) begin
          n_fail++;
          $display("FAIL amo_store_payload: got wdata=%h ops=%0d expected 12345678 2",
                   dbus_w_data_o, dbus_st_ops_o);
        end
      end
      tick();
      rd            = 32'h0BAD_0000 + 32'(k);
      dbus_ack_i    = 1'b1;
      dbus_r_data_i = rd;
      #1;
      n_checks++;
      if ({ptw_ack_o, lsu_ack_o} !== (e.ptw ? 2'b10 : 2'b01) ||
          (e.ptw ? ptw_r_data_o : lsu_r_data_o) !== rd) begin
        n_fail++;
        $display("FAIL amo_ack: step %0d got ptw_ack=%b lsu_ack=%b lsu=%h ptw=%h expected ptw=%b data=%h",
                 k, ptw_ack_o, lsu_ack_o, lsu_r_data_o, ptw_r_data_o, e.ptw, rd);
      end
      tick();
      dbus_ack_i = 1'b0;
      if (k == 0) begin
        lsu_ld_req_i = 1'b0;
        lsu_st_req_i = 1'b1;
        lsu_w_data_i = 32'h1234_5678;
        lsu_st_ops_i = 3'd2;
      end else if (k == 1) begin
        lsu_st_req_i = 1'b0;
        lsu_lock_i   = 1'b0;
      end else begin
        ptw_ld_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_flush();
    exp_t            e;
    bit              seen;
    do_reset();
    exp_q.push_back('{ptw: 1'b1, st: 1'b0, addr: 32'h0000_6000});
    lsu_ld_req_i = 1'b1;
    lsu_addr_i   = 32'h0000_5000;
    ptw_ld_req_i = 1'b1;
    ptw_addr_i   = 32'h0000_6000;
    wait_bus(6, seen);
    n_checks++;
    if (!seen || dbus_addr_o !== 32'h0000_5000) begin
      n_fail++;
      $display("FAIL flush_grant_l: got seen=%b addr=%h expected 00005000", seen, dbus_addr_o);
    end
    tick();
    lsu_flush_i = 1'b1;
    tick();
    lsu_flush_i  = 1'b0;
    lsu_ld_req_i = 1'b0;
    #1;
    n_checks++;
    if (dbus_ld_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_drain_hold: dbus_ld_req_o got %b expected 1", dbus_ld_req_o);
    end
    tick();
    dbus_ack_i    = 1'b1;
    dbus_r_data_i = 32'h1111_2222;
    #1;
    n_checks++;
    if ({ptw_ack_o, lsu_ack_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_ack_suppressed: got ptw_ack=%b lsu_ack=%b expected 0 0", ptw_ack_o, lsu_ack_o);
    end
    tick();
    dbus_ack_i = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if ({dbus_ld_req_o, dbus_addr_o} !== {1'b1, e.addr}) begin
      n_fail++;
      $display("FAIL flush_p_grant: got ld=%b addr=%h expected ld=1 addr=%h", dbus_ld_req_o, dbus_addr_o, e.addr);
    end
    tick();
    dbus_ack_i    = 1'b1;
    dbus_r_data_i = 32'h3333_4444;
    #1;
    n_checks++;
    if ({ptw_ack_o, lsu_ack_o} !== (e.ptw ? 2'b10 : 2'b01) || ptw_r_data_o !== 32'h3333_4444) begin
      n_fail++;
      $display("FAIL flush_p_ack: got ptw_ack=%b lsu_ack=%b data=%h expected ptw_ack=1 data=33334444",
               ptw_ack_o, lsu_ack_o, ptw_r_data_o);
    end
    tick();
    dbus_ack_i   = 1'b0;
    ptw_ld_req_i = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   seen;
    int   pulses;
    do_reset();
    lsu_ld_req_i = 1'b1;
    lsu_addr_i   = 32'h0000_7000;
    wait_bus(6, seen);
    pulses = timeout_err_o ? 1 : 0;
    repeat (6) begin
      tick();
      if (timeout_err_o) pulses++;
    end
    n_checks++;
    if (!seen || pulses != 0) begin
      n_fail++;
      $display("FAIL to_early: got seen=%b early pulses=%0d expected seen=1 pulses=0", seen, pulses);
    end
    tick();
    n_checks++;
    if ({timeout_err_o, lsu_ack_o, ptw_ack_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL to_pulse: got err=%b lsu_ack=%b ptw_ack=%b expected 1 0 0",
               timeout_err_o, lsu_ack_o, ptw_ack_o);
    end
    tick();
    lsu_ld_req_i = 1'b0;
    n_checks++;
    if ({dbus_ld_req_o, timeout_err_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL to_abort: got ld=%b err=%b expected 0 0", dbus_ld_req_o, timeout_err_o);
    end
    tick();
    exp_q.push_back('{ptw: 1'b0, st: 1'b0, addr: 32'h0000_7100});
    lsu_ld_req_i = 1'b1;
    lsu_addr_i   = 32'h0000_7100;
    wait_bus(6, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || dbus_addr_o !== e.addr) begin
      n_fail++;
      $display("FAIL to_regrant: got seen=%b addr=%h expected %h", seen, dbus_addr_o, e.addr);
    end
    repeat (7) tick();
    dbus_ack_i    = 1'b1;
    dbus_r_data_i = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if ({timeout_err_o, ptw_ack_o, lsu_ack_o} !== 3'b001 || lsu_r_data_o !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL to_ack_wins: got err=%b ptw_ack=%b lsu_ack=%b data=%h expected 0 0 1 cafef00d",
               timeout_err_o, ptw_ack_o, lsu_ack_o, lsu_r_data_o);
    end
    tick();
    dbus_ack_i   = 1'b0;
    lsu_ld_req_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    do_reset();
    ptw_ld_req_i = 1'b1;
    ptw_addr_i   = 32'h0000_9000;
    wait_bus(6, seen);
    n_checks++;
    if (!seen || dbus_addr_o !== 32'h0000_9000) begin
      n_fail++;
      $display("FAIL rst_mid_busy: got seen=%b addr=%h expected 00009000", seen, dbus_addr_o);
    end
    tick();
    rst_n        = 1'b0;
    lsu_ld_req_i = 1'b1;
    lsu_addr_i   = 32'h0000_A000;
    exp_q.push_back('{ptw: 1'b0, st: 1'b0, addr: 32'h0000_A000});
    tick();
    dbus_ack_i = 1'b1;
    #1;
    n_checks++;
    if ({dbus_ld_req_o, dbus_st_req_o, lsu_ack_o, ptw_ack_o, timeout_err_o} !== 5'b0 ||
        {dbus_addr_o, dbus_w_data_o, dbus_st_ops_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got ld=%b st=%b lsu_ack=%b ptw_ack=%b err=%b addr=%h expected all 0",
               dbus_ld_req_o, dbus_st_req_o, lsu_ack_o, ptw_ack_o, timeout_err_o, dbus_addr_o);
    end
    dbus_ack_i = 1'b0;
    rst_n      = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if ({dbus_ld_req_o, dbus_addr_o} !== {1'b1, e.addr}) begin
      n_fail++;
      $display("FAIL rst_tie_l: got ld=%b addr=%h expected ld=1 addr=%h", dbus_ld_req_o, dbus_addr_o, e.addr);
    end
    tick();
    dbus_ack_i    = 1'b1;
    dbus_r_data_i = 32'h5555_6666;
    #1;
    n_checks++;
    if ({ptw_ack_o, lsu_ack_o} !== (e.ptw ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL rst_tie_ack: got ptw_ack=%b lsu_ack=%b expected lsu_ack=1", ptw_ack_o, lsu_ack_o);
    end
    tick();
    dbus_ack_i   = 1'b0;
    lsu_ld_req_i = 1'b0;
    ptw_ld_req_i = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_amo_lock();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no end expected end by 200000");
    $fatal(1, "bench did not terminate");
  end

endmodule
